// File: rtl/arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | arb_pkg : state encoding, arbitration-mode constants and clog2 helper      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_UP_REQ  = 2'd1,
        ST_GRANT   = 2'd2,
        ST_RELEASE = 2'd3
    } arb_state_e;

    localparam logic C_MODE_FIXED = 1'b0;
    localparam logic C_MODE_RR    = 1'b1;

    // Ceiling log2; returns 0 for values of 0 or 1, callers clamp to 1 bit.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage : arb_pkg
`default_nettype wire

// File: rtl/arb_rr_pick.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | arb_rr_pick : combinational winner select, fixed-priority or round-robin  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module arb_rr_pick
    import arb_pkg::*;
#(
    parameter int C_NUM_CH = 4,
    parameter int C_PTR_W  = 2
) (
    input  logic [C_NUM_CH-1:0] i_req,
    input  logic [C_PTR_W-1:0]  i_ptr,
    input  logic                i_mode,
    output logic [C_NUM_CH-1:0] o_onehot,
    output logic [C_PTR_W-1:0]  o_idx
);

    logic               found;
    logic [C_PTR_W-1:0] cand;
    int                 sum;

    // Scan outward from the start point; fixed mode always starts at channel 0.
    always_comb begin
        o_onehot = '0;
        o_idx    = '0;
        found    = 1'b0;
        cand     = '0;
        sum      = 0;
        for (int i = 0; i < C_NUM_CH; i++) begin
            if (i_mode == C_MODE_RR) begin
                sum = int'(i_ptr) + i;
                if (sum >= C_NUM_CH) begin
                    sum = sum - C_NUM_CH;
                end
            end else begin
                sum = i;
            end
            cand = C_PTR_W'(sum);
            if (!found && i_req[cand]) begin
                found          = 1'b1;
                o_onehot[cand] = 1'b1;
                o_idx          = cand;
            end
        end
    end

endmodule : arb_rr_pick
`default_nettype wire

// File: rtl/arb_rr_concentrator.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | arb_rr_concentrator : N-channel grant concentrator behind an upstream     |
// | arbiter, with optional hold limit and release handshake.                  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module arb_rr_concentrator
    import arb_pkg::*;
#(
    parameter int C_NUM_CH       = 4,
    parameter int C_ARB_MODE     = 1,
    parameter int C_HAS_UPSTREAM = 1,
    parameter int C_MAX_HOLD     = 0
) (
    input  logic                aclk,
    input  logic                areset,
    input  logic [C_NUM_CH-1:0] s_req,
    output logic [C_NUM_CH-1:0] s_gnt,
    output logic [C_NUM_CH-1:0] s_rel,
    output logic                m_req,
    input  logic                m_gnt,
    input  logic                m_rel
);

    localparam int C_PTR_W = (clog2(C_NUM_CH) < 1) ? 1 : clog2(C_NUM_CH);
    localparam int C_CNT_W = (clog2(C_MAX_HOLD + 1) < 1) ? 1 : clog2(C_MAX_HOLD + 1);

    localparam logic               C_MODE      = (C_ARB_MODE == 1) ? C_MODE_RR : C_MODE_FIXED;
    localparam logic               C_UP        = (C_HAS_UPSTREAM != 0);
    localparam logic               C_HOLD_EN   = (C_MAX_HOLD > 0);
    localparam logic [C_CNT_W-1:0] C_HOLD_LAST = C_CNT_W'(C_MAX_HOLD - 1);
    localparam logic [C_PTR_W-1:0] C_LAST_CH   = C_PTR_W'(C_NUM_CH - 1);

    arb_state_e          state_q, state_d;
    logic [C_PTR_W-1:0]  win_q, win_d;
    logic [C_PTR_W-1:0]  ptr_q, ptr_d;
    logic [C_CNT_W-1:0]  cnt_q, cnt_d;
    logic [C_NUM_CH-1:0] s_gnt_q, s_gnt_d;
    logic [C_NUM_CH-1:0] s_rel_q, s_rel_d;
    logic                m_req_q, m_req_d;

    logic [C_NUM_CH-1:0] w_pick_onehot;
    logic [C_PTR_W-1:0]  w_pick_idx;
    logic                w_holder_req;
    logic                w_rel_cause;
    logic                w_enter_grant;
    logic                w_exit_idle;

    arb_rr_pick #(
        .C_NUM_CH (C_NUM_CH),
        .C_PTR_W  (C_PTR_W)
    ) u_pick (
        .i_req    (s_req),
        .i_ptr    (ptr_q),
        .i_mode   (C_MODE),
        .o_onehot (w_pick_onehot),
        .o_idx    (w_pick_idx)
    );

    assign w_holder_req = s_req[win_q];
    assign w_rel_cause  = (C_UP && (m_rel || !m_gnt)) || (C_HOLD_EN && (cnt_q == C_HOLD_LAST));

    always_comb begin
        state_d       = state_q;
        win_d         = win_q;
        ptr_d         = ptr_q;
        cnt_d         = cnt_q;
        s_gnt_d       = s_gnt_q;
        s_rel_d       = s_rel_q;
        m_req_d       = m_req_q;
        w_enter_grant = 1'b0;
        w_exit_idle   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (|s_req) begin
                    if (C_UP) begin
                        state_d = ST_UP_REQ;
                        m_req_d = 1'b1;
                    end else begin
                        w_enter_grant = 1'b1;
                    end
                end
            end
            ST_UP_REQ: begin
                // Requesters giving up wins over a late upstream grant.
                if (s_req == '0) begin
                    state_d = ST_IDLE;
                    m_req_d = 1'b0;
                end else if (m_gnt) begin
                    w_enter_grant = 1'b1;
                end
            end
            ST_GRANT: begin
                if (cnt_q != '1) begin
                    cnt_d = cnt_q + C_CNT_W'(1);
                end
                if (!w_holder_req) begin
                    w_exit_idle = 1'b1;
                end else if (w_rel_cause) begin
                    state_d = ST_RELEASE;
                    s_rel_d = s_gnt_q;
                end
            end
            ST_RELEASE: begin
                if (!w_holder_req) begin
                    w_exit_idle = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (w_enter_grant) begin
            state_d = ST_GRANT;
            win_d   = w_pick_idx;
            s_gnt_d = w_pick_onehot;
            cnt_d   = '0;
            m_req_d = C_UP;
        end

        if (w_exit_idle) begin
            state_d = ST_IDLE;
            s_gnt_d = '0;
            s_rel_d = '0;
            m_req_d = 1'b0;
            if (C_MODE == C_MODE_RR) begin
                ptr_d = (win_q == C_LAST_CH) ? '0 : win_q + C_PTR_W'(1);
            end
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q <= ST_IDLE;
            win_q   <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            s_gnt_q <= '0;
            s_rel_q <= '0;
            m_req_q <= 1'b0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            s_gnt_q <= s_gnt_d;
            s_rel_q <= s_rel_d;
            m_req_q <= m_req_d;
        end
    end

    assign s_gnt = s_gnt_q;
    assign s_rel = s_rel_q;
    assign m_req = m_req_q;

endmodule : arb_rr_concentrator
`default_nettype wire
